// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//
// Shares register file write port 3 between the in-order pipeline writeback
// stage and a long-latency unit (mul/div, load-miss return). Pipeline
// writes always win. Long-latency results either bypass straight onto the
// port when it is idle and nothing is queued, or wait in a small FIFO that
// drains whenever the pipeline leaves the port free. A starvation counter
// raises wb_stall so that a queued result cannot be denied forever. A
// 32-bit pending scoreboard tracks destination registers whose long-latency
// result has not yet been written, so decode can detect RAW and WAW hazards.
//
// Parameters
//   DEPTH       FIFO entries. Must be a power of two and at least 2.
//   MAX_WAIT    denied cycles a non-empty FIFO tolerates before wb_stall.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   wb_valid/rd/data    pipeline writeback request
//   lu_valid/rd/data    long-latency result offer
//   lu_ready            result accepted on lu_valid && lu_ready
//   issue_valid/rd      decode issuing a long-latency op
//   issue_ready         issue to issue_rd is legal (not pending or x0)
//   rs1, rs2            decode source registers
//   raw_hazard          rs1 or rs2 has an outstanding long-latency result
//   wb_stall            registered; pipeline must hold wb_valid low
//   write_en3/addr3/write_data3  register file write port, committed on negedge
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        lu_valid,
    input  logic [4:0]  lu_rd,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic        issue_ready,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        raw_hazard,
    output logic        wb_stall,
    output logic        write_en3,
    output logic [4:0]  addr3,
    output logic [31:0] write_data3
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(MAX_WAIT + 1) + 1;

    localparam logic [AW:0]   LP_FULL      = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] LP_WAIT_LAST = CW'(MAX_WAIT - 1);
    localparam logic [CW-1:0] LP_WAIT_MAX  = CW'(MAX_WAIT);

    // FIFO storage (data path, not reset)
    logic [4:0]    r_fifo_rd   [DEPTH];
    logic [31:0]   r_fifo_data [DEPTH];

    // Control state
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [31:0]   r_pending;
    logic [CW-1:0] r_wait_cnt;
    logic          r_wb_stall;

    // Combinational decisions
    logic          w_empty;
    logic          w_full;
    logic [4:0]    w_head_rd;
    logic [31:0]   w_head_data;
    logic          w_wb_req;
    logic          w_head_grant;
    logic          w_head_denied;
    logic          w_bypass;
    logic          w_lu_ready;
    logic          w_push;
    logic          w_issue_ready;
    logic          w_we;
    logic [4:0]    w_addr;
    logic [31:0]   w_data;
    logic [31:0]   w_set_mask;
    logic [31:0]   w_clr_mask;
    logic [31:0]   w_pending_nxt;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == LP_FULL);
    assign w_head_rd   = r_fifo_rd[r_rptr];
    assign w_head_data = r_fifo_data[r_rptr];

    // A pipeline write to x0 is a no-op and leaves the port free.
    assign w_wb_req      = wb_valid && (wb_rd != 5'd0);
    assign w_head_grant  = !reset && !w_wb_req && !w_empty;
    assign w_head_denied = !w_empty && !w_head_grant;
    // Bypass only when nothing is queued, so results stay in order.
    assign w_bypass      = !reset && !w_wb_req && w_empty && lu_valid && (lu_rd != 5'd0);

    // A full FIFO can still accept when its head leaves this cycle.
    assign w_lu_ready = !reset && (!w_full || w_head_grant);
    // x0 results are accepted but never stored.
    assign w_push     = lu_valid && w_lu_ready && !w_bypass && (lu_rd != 5'd0);

    // pending[0] is always 0, so x0 is always issuable and never a hazard.
    assign w_issue_ready = !r_pending[issue_rd];

    always_comb begin
        w_we   = 1'b0;
        w_addr = 5'd0;
        w_data = 32'd0;
        if (!reset && w_wb_req) begin
            w_we   = 1'b1;
            w_addr = wb_rd;
            w_data = wb_data;
        end else if (w_head_grant) begin
            w_we   = 1'b1;
            w_addr = w_head_rd;
            w_data = w_head_data;
        end else if (w_bypass) begin
            w_we   = 1'b1;
            w_addr = lu_rd;
            w_data = lu_data;
        end
    end

    // Set and clear never target the same register: issue_ready blocks issue
    // to a pending rd, and only pending rds have results in flight.
    always_comb begin
        w_set_mask = 32'd0;
        w_clr_mask = 32'd0;
        if (issue_valid && w_issue_ready && (issue_rd != 5'd0)) begin
            w_set_mask[issue_rd] = 1'b1;
        end
        if (w_head_grant) begin
            w_clr_mask[w_head_rd] = 1'b1;
        end else if (w_bypass) begin
            w_clr_mask[lu_rd] = 1'b1;
        end
        w_pending_nxt    = (r_pending & ~w_clr_mask) | w_set_mask;
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wptr]   <= lu_rd;
            r_fifo_data[r_wptr] <= lu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_pending  <= 32'd0;
            r_wait_cnt <= '0;
            r_wb_stall <= 1'b0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_head_grant) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_head_grant})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            r_pending <= w_pending_nxt;

            // Saturating count of consecutive cycles the head was refused.
            if (w_head_denied) begin
                if (r_wait_cnt != LP_WAIT_MAX) begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                end
            end else begin
                r_wait_cnt <= '0;
            end

            // Stall after the MAX_WAIT-th denied cycle; release once the head
            // has been written.
            if (w_head_denied && (r_wait_cnt >= LP_WAIT_LAST)) begin
                r_wb_stall <= 1'b1;
            end else if (w_head_grant) begin
                r_wb_stall <= 1'b0;
            end
        end
    end

    assign lu_ready    = w_lu_ready;
    assign issue_ready = w_issue_ready;
    assign raw_hazard  = r_pending[rs1] | r_pending[rs2];
    assign wb_stall    = r_wb_stall;
    assign write_en3   = w_we;
    assign addr3       = w_addr;
    assign write_data3 = w_data;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_port_arbiter
//
// Self-checking bench for wb_port_arbiter (DEPTH = 2, MAX_WAIT = 4).
// Each scenario task drives inputs just after a rising edge and checks
// outputs on the falling edge. Every register file write the bench expects
// is pushed onto exp_q in the order it should appear; a monitor pops and
// compares each write the DUT actually makes.
// ---------------------------------------------------------------------------
module tb_wb_port_arbiter;

    logic        clk;
    logic        reset;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        raw_hazard;
    logic        wb_stall;
    logic        write_en3;
    logic [4:0]  addr3;
    logic [31:0] write_data3;

    int vectors     = 0;
    int miscompares = 0;

    logic [36:0] exp_q[$];
    logic [36:0] mon_exp;

    wb_port_arbiter #(
        .DEPTH    (2),
        .MAX_WAIT (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .lu_valid    (lu_valid),
        .lu_rd       (lu_rd),
        .lu_data     (lu_data),
        .lu_ready    (lu_ready),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .rs1         (rs1),
        .rs2         (rs2),
        .raw_hazard  (raw_hazard),
        .wb_stall    (wb_stall),
        .write_en3   (write_en3),
        .addr3       (addr3),
        .write_data3 (write_data3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected $finish earlier");
        $fatal(1, "watchdog expired");
    end

    // Write-port scoreboard.
    always @(negedge clk) begin
        if (write_en3 === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL write_port: got write addr3=%0d data=%h, required no write",
                         addr3, write_data3);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({addr3, write_data3} !== mon_exp) begin
                    miscompares++;
                    $display("FAIL write_port: got addr3=%0d data=%h, required addr3=%0d data=%h",
                             addr3, write_data3, mon_exp[36:32], mon_exp[31:0]);
                end
            end
        end else if (write_en3 !== 1'b0) begin
            vectors++;
            miscompares++;
            $display("FAIL write_en3_known: got %b, required 0 or 1", write_en3);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_valid    = 1'b0;
        wb_rd       = 5'd0;
        wb_data     = 32'd0;
        lu_valid    = 1'b0;
        lu_rd       = 5'd0;
        lu_data     = 32'd0;
        issue_valid = 1'b0;
        issue_rd    = 5'd0;
        rs1         = 5'd0;
        rs2         = 5'd0;
    endtask

    task automatic check_drained(input string name);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drained: got %0d writes still outstanding, required 0",
                     name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) tick();
        lu_valid = 1'b1;
        lu_rd    = 5'd4;
        issue_rd = 5'd7;
        rs1      = 5'd7;
        @(negedge clk);
        vectors += 7;
        if (lu_ready !== 1'b0)     begin miscompares++; $display("FAIL rst_lu_ready: got %b, required 0", lu_ready); end
        if (write_en3 !== 1'b0)    begin miscompares++; $display("FAIL rst_write_en3: got %b, required 0", write_en3); end
        if (addr3 !== 5'd0)        begin miscompares++; $display("FAIL rst_addr3: got %0d, required 0", addr3); end
        if (write_data3 !== 32'd0) begin miscompares++; $display("FAIL rst_write_data3: got %h, required 0", write_data3); end
        if (issue_ready !== 1'b1)  begin miscompares++; $display("FAIL rst_issue_ready: got %b, required 1", issue_ready); end
        if (raw_hazard !== 1'b0)   begin miscompares++; $display("FAIL rst_raw_hazard: got %b, required 0", raw_hazard); end
        if (wb_stall !== 1'b0)     begin miscompares++; $display("FAIL rst_wb_stall: got %b, required 0", wb_stall); end
        tick();
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        vectors++;
        if (lu_ready !== 1'b1) begin miscompares++; $display("FAIL idle_lu_ready: got %b, required 1", lu_ready); end
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (write_en3 !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_write_en3 cycle %0d: got %b, required 0", i, write_en3);
            end
            tick();
            @(negedge clk);
        end
        tick();
        check_drained("reset");
    endtask

    task automatic test_pipeline();
        idle_inputs();
        wb_valid = 1'b1;
        wb_rd    = 5'd5;
        wb_data  = 32'hDEADBEEF;
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        @(negedge clk);
        vectors++;
        if (write_en3 !== 1'b1) begin miscompares++; $display("FAIL pipe_write_en3: got %b, required 1", write_en3); end
        tick();
        wb_rd   = 5'd0;
        wb_data = 32'h0BADF00D;
        @(negedge clk);
        vectors++;
        if (write_en3 !== 1'b0) begin miscompares++; $display("FAIL pipe_rd0_write_en3: got %b, required 0", write_en3); end
        tick();
        idle_inputs();
        check_drained("pipeline");
    endtask

    task automatic test_bypass();
        idle_inputs();
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        rs1         = 5'd7;
        @(negedge clk);
        vectors += 2;
        if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL byp_issue_ready_first: got %b, required 1", issue_ready); end
        if (raw_hazard !== 1'b0)  begin miscompares++; $display("FAIL byp_raw_same_cycle: got %b, required 0", raw_hazard); end
        tick();
        issue_valid = 1'b0;
        @(negedge clk);
        vectors += 2;
        if (raw_hazard !== 1'b1)  begin miscompares++; $display("FAIL byp_raw_after_issue: got %b, required 1", raw_hazard); end
        if (issue_ready !== 1'b0) begin miscompares++; $display("FAIL byp_issue_ready_pending: got %b, required 0", issue_ready); end
        tick();
        lu_valid = 1'b1;
        lu_rd    = 5'd7;
        lu_data  = 32'h12345678;
        exp_q.push_back({5'd7, 32'h12345678});
        @(negedge clk);
        vectors += 2;
        if (lu_ready !== 1'b1)  begin miscompares++; $display("FAIL byp_lu_ready: got %b, required 1", lu_ready); end
        if (write_en3 !== 1'b1) begin miscompares++; $display("FAIL byp_write_en3: got %b, required 1", write_en3); end
        tick();
        lu_valid = 1'b0;
        @(negedge clk);
        vectors += 3;
        if (raw_hazard !== 1'b0)  begin miscompares++; $display("FAIL byp_raw_cleared: got %b, required 0", raw_hazard); end
        if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL byp_issue_ready_back: got %b, required 1", issue_ready); end
        if (write_en3 !== 1'b0)   begin miscompares++; $display("FAIL byp_no_second_write: got %b, required 0", write_en3); end
        tick();
        idle_inputs();
        check_drained("bypass");
    endtask

    task automatic test_contention();
        idle_inputs();
        issue_valid = 1'b1;
        issue_rd    = 5'd3;
        tick();
        issue_valid = 1'b0;
        rs1         = 5'd3;
        for (int i = 0; i < 5; i++) begin
            wb_valid = 1'b1;
            wb_rd    = 5'd10;
            wb_data  = 32'h10000000 + i;
            lu_valid = (i == 0);
            lu_rd    = 5'd3;
            lu_data  = 32'hAAAA0003;
            exp_q.push_back({5'd10, 32'h10000000 + i});
            @(negedge clk);
            vectors += 3;
            if (lu_ready !== 1'b1)   begin miscompares++; $display("FAIL cont_lu_ready cycle %0d: got %b, required 1", i, lu_ready); end
            if (wb_stall !== 1'b0)   begin miscompares++; $display("FAIL cont_stall_low cycle %0d: got %b, required 0", i, wb_stall); end
            if (raw_hazard !== 1'b1) begin miscompares++; $display("FAIL cont_raw cycle %0d: got %b, required 1", i, raw_hazard); end
            tick();
        end
        wb_valid = 1'b0;
        lu_valid = 1'b0;
        exp_q.push_back({5'd3, 32'hAAAA0003});
        @(negedge clk);
        vectors += 2;
        if (wb_stall !== 1'b1)  begin miscompares++; $display("FAIL cont_stall_high: got %b, required 1", wb_stall); end
        if (write_en3 !== 1'b1) begin miscompares++; $display("FAIL cont_head_write: got %b, required 1", write_en3); end
        tick();
        @(negedge clk);
        vectors += 3;
        if (wb_stall !== 1'b0)   begin miscompares++; $display("FAIL cont_stall_fall: got %b, required 0", wb_stall); end
        if (raw_hazard !== 1'b0) begin miscompares++; $display("FAIL cont_raw_cleared: got %b, required 0", raw_hazard); end
        if (write_en3 !== 1'b0)  begin miscompares++; $display("FAIL cont_idle_after: got %b, required 0", write_en3); end
        tick();
        idle_inputs();
        check_drained("contention");
    endtask

    task automatic test_fill();
        idle_inputs();
        // C0, C1: pipeline holds the port, two results enqueue.
        for (int i = 0; i < 2; i++) begin
            wb_valid = 1'b1;
            wb_rd    = 5'd12;
            wb_data  = 32'h20000000 + i;
            lu_valid = 1'b1;
            lu_rd    = 5'd20 + 5'(i);
            lu_data  = 32'hB0000000 + i;
            exp_q.push_back({5'd12, 32'h20000000 + i});
            @(negedge clk);
            vectors++;
            if (lu_ready !== 1'b1) begin miscompares++; $display("FAIL fill_lu_ready cycle %0d: got %b, required 1", i, lu_ready); end
            tick();
        end
        // C2: full with no pop.
        wb_data  = 32'h20000002;
        lu_rd    = 5'd22;
        lu_data  = 32'hB0000002;
        exp_q.push_back({5'd12, 32'h20000002});
        @(negedge clk);
        vectors++;
        if (lu_ready !== 1'b0) begin miscompares++; $display("FAIL fill_full_lu_ready: got %b, required 0", lu_ready); end
        tick();
        // C3: head pops while the third result pushes.
        wb_valid = 1'b0;
        exp_q.push_back({5'd20, 32'hB0000000});
        @(negedge clk);
        vectors++;
        if (lu_ready !== 1'b1) begin miscompares++; $display("FAIL fill_pop_push_lu_ready: got %b, required 1", lu_ready); end
        tick();
        // C4: still full.
        wb_valid = 1'b1;
        wb_data  = 32'h20000004;
        lu_valid = 1'b0;
        exp_q.push_back({5'd12, 32'h20000004});
        @(negedge clk);
        vectors++;
        if (lu_ready !== 1'b0) begin miscompares++; $display("FAIL fill_still_full: got %b, required 0", lu_ready); end
        tick();
        // C5, C6: drain across the pointer wrap.
        wb_valid = 1'b0;
        exp_q.push_back({5'd21, 32'hB0000001});
        @(negedge clk);
        tick();
        exp_q.push_back({5'd22, 32'hB0000002});
        @(negedge clk);
        tick();
        @(negedge clk);
        vectors += 2;
        if (write_en3 !== 1'b0) begin miscompares++; $display("FAIL fill_empty_write_en3: got %b, required 0", write_en3); end
        if (lu_ready !== 1'b1)  begin miscompares++; $display("FAIL fill_empty_lu_ready: got %b, required 1", lu_ready); end
        tick();
        // x0 result: accepted and dropped.
        lu_valid = 1'b1;
        lu_rd    = 5'd0;
        lu_data  = 32'hCCCCCCCC;
        @(negedge clk);
        vectors += 2;
        if (lu_ready !== 1'b1)  begin miscompares++; $display("FAIL rd0_lu_ready: got %b, required 1", lu_ready); end
        if (write_en3 !== 1'b0) begin miscompares++; $display("FAIL rd0_write_en3: got %b, required 0", write_en3); end
        tick();
        lu_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (write_en3 !== 1'b0) begin miscompares++; $display("FAIL rd0_not_queued: got %b, required 0", write_en3); end
        tick();
        idle_inputs();
        check_drained("fill");
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        issue_valid = 1'b1;
        issue_rd    = 5'd3;
        tick();
        issue_rd    = 5'd9;
        tick();
        issue_valid = 1'b0;
        rs1         = 5'd3;
        rs2         = 5'd0;
        for (int i = 0; i < 2; i++) begin
            wb_valid = 1'b1;
            wb_rd    = 5'd15;
            wb_data  = 32'h30000000 + i;
            lu_valid = 1'b1;
            lu_rd    = (i == 0) ? 5'd3 : 5'd9;
            lu_data  = 32'hD0000000 + i;
            exp_q.push_back({5'd15, 32'h30000000 + i});
            @(negedge clk);
            vectors++;
            if (raw_hazard !== 1'b1) begin miscompares++; $display("FAIL rmid_raw_rs1 cycle %0d: got %b, required 1", i, raw_hazard); end
            tick();
        end
        wb_valid = 1'b0;
        lu_valid = 1'b0;
        rs1      = 5'd0;
        rs2      = 5'd9;
        reset    = 1'b1;
        @(negedge clk);
        vectors += 3;
        if (raw_hazard !== 1'b1) begin miscompares++; $display("FAIL rmid_raw_rs2: got %b, required 1", raw_hazard); end
        if (write_en3 !== 1'b0)  begin miscompares++; $display("FAIL rmid_write_in_reset: got %b, required 0", write_en3); end
        if (lu_ready !== 1'b0)   begin miscompares++; $display("FAIL rmid_lu_ready_in_reset: got %b, required 0", lu_ready); end
        tick();
        reset    = 1'b0;
        rs1      = 5'd3;
        issue_rd = 5'd9;
        @(negedge clk);
        vectors += 5;
        if (write_en3 !== 1'b0)   begin miscompares++; $display("FAIL rmid_fifo_empty: got %b, required 0", write_en3); end
        if (raw_hazard !== 1'b0)  begin miscompares++; $display("FAIL rmid_pending_clear: got %b, required 0", raw_hazard); end
        if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_issue_ready: got %b, required 1", issue_ready); end
        if (wb_stall !== 1'b0)    begin miscompares++; $display("FAIL rmid_wb_stall: got %b, required 0", wb_stall); end
        if (lu_ready !== 1'b1)    begin miscompares++; $display("FAIL rmid_lu_ready: got %b, required 1", lu_ready); end
        tick();
        @(negedge clk);
        vectors++;
        if (write_en3 !== 1'b0) begin miscompares++; $display("FAIL rmid_no_late_write: got %b, required 0", write_en3); end
        tick();
        idle_inputs();
        check_drained("reset_mid");
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_pipeline();
        test_bypass();
        test_contention();
        test_fill();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
